// File: rtl/goldschmidt_prenorm.sv
// Operand pre-normalizer for the goldschmidt divider: left-justifies both
// operands one bit per cycle, starts the divider, and reports shift counts.
module goldschmidt_prenorm #(
  parameter int WIDTH = 32,
  parameter int SW    = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  output logic             div_start,
  input  logic             div_busy,
  input  logic             div_ready,
  output logic [SW-1:0]    sx,
  output logic [SW-1:0]    sy,
  output logic             done,
  output logic             err_div0,
  output logic             zero_q
);

  typedef enum logic [2:0] {S_IDLE, S_NORM, S_ISSUE, S_WAIT, S_FIN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [SW-1:0]    sx_q, sx_d, sy_q, sy_d;
  logic             err_q, err_d, zq_q, zq_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    err_d   = err_q;
    zq_d    = zq_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d   = x;
          b_d   = y;
          sx_d  = '0;
          sy_d  = '0;
          err_d = 1'b0;
          zq_d  = 1'b0;
          // Divide-by-zero wins over a zero dividend; both bypass the divider.
          if (y == '0) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else if (x == '0) begin
            zq_d    = 1'b1;
            state_d = S_FIN;
          end else begin
            state_d = S_NORM;
          end
        end
      end
      S_NORM: begin
        if (a_q[WIDTH-1] && b_q[WIDTH-1]) begin
          state_d = S_ISSUE;
        end else begin
          if (!a_q[WIDTH-1]) begin
            a_d  = a_q << 1;
            sx_d = sx_q + SW'(1);
          end
          if (!b_q[WIDTH-1]) begin
            b_d  = b_q << 1;
            sy_d = sy_q + SW'(1);
          end
        end
      end
      S_ISSUE: if (!div_busy)  state_d = S_WAIT;
      S_WAIT:  if (div_ready)  state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      err_q   <= 1'b0;
      zq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      err_q   <= err_d;
      zq_q    <= zq_d;
    end
  end

  // Start depends on the live busy flag so an idle divider is hit in the
  // first ISSUE cycle.
  assign div_start = (state_q == S_ISSUE) && !div_busy;
  assign in_ready  = (state_q == S_IDLE);
  assign done      = (state_q == S_FIN);
  assign div_a     = a_q;
  assign div_b     = b_q;
  assign sx        = sx_q;
  assign sy        = sy_q;
  assign err_div0  = err_q;
  assign zero_q    = zq_q;

endmodule

// File: tb/tb_goldschmidt_prenorm.sv
// Vector table plus scoreboard bench for goldschmidt_prenorm; also covers a
// busy divider with back-to-back valid and a reset during WAIT.
module tb_goldschmidt_prenorm;

  logic        clk = 1'b0;
  logic        clr;
  logic        in_valid, in_ready;
  logic [31:0] x, y, div_a, div_b;
  logic        div_start, div_busy, div_ready;
  logic [4:0]  sx, sy;
  logic        done, err_div0, zero_q;

  goldschmidt_prenorm #(.WIDTH(32), .SW(5)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .div_a(div_a), .div_b(div_b), .div_start(div_start),
    .div_busy(div_busy), .div_ready(div_ready), .sx(sx), .sy(sy),
    .done(done), .err_div0(err_div0), .zero_q(zero_q)
  );

  always #5 clk = ~clk;

  // lat = cycles from accept edge to div_start with an idle divider; 0 = trap
  typedef struct {
    logic [31:0] x, y, a, b;
    logic [4:0]  sx, sy;
    logic        err, zq;
    int          lat;
  } vec_t;

  vec_t vecs[8];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic start_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard side: every done pops one expected result.
  always @(negedge clk) begin
    if (!clr) begin
      if (div_start) begin
        chk("start_not_back_to_back", {31'd0, start_prev}, 32'd0);
        chk("start_not_in_idle", {31'd0, in_ready}, 32'd0);
      end
      start_prev <= div_start;
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          vec_t e;
          e = sb.pop_front();
          chk("div_a", div_a, e.a);
          chk("div_b", div_b, e.b);
          chk("sx", {27'd0, sx}, {27'd0, e.sx});
          chk("sy", {27'd0, sy}, {27'd0, e.sy});
          chk("err_div0", {31'd0, err_div0}, {31'd0, e.err});
          chk("zero_q", {31'd0, zero_q}, {31'd0, e.zq});
        end
      end
    end
  end

  // Called and returns at a negedge. hold keeps in_valid high and presents
  // the next pair (nx, ny) right after this one is accepted.
  task automatic run(input vec_t v, input int busy_n, input bit hold,
                     input logic [31:0] nx, input logic [31:0] ny);
    int k, st_k, st_n, dn_k;
    bit rdy_bad;
    x = v.x; y = v.y; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    sb.push_back(v);
    if (hold) begin x = nx; y = ny; end
    else in_valid = 1'b0;
    st_k = -1; st_n = 0; dn_k = -1; rdy_bad = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (div_start) begin
        st_n++;
        if (st_k < 0) st_k = c;
      end
      if (done) begin
        dn_k = c;
        break;
      end
      if (in_ready) rdy_bad = 1'b1;
      @(posedge clk); #1;
      div_busy  = (v.lat > 0) && (c + 1 >= v.lat) && (c + 1 < v.lat + busy_n);
      div_ready = (st_k >= 0) && (c + 1 == st_k + 3);
    end
    div_busy = 1'b0; div_ready = 1'b0;
    chk("in_ready_low_while_busy", {31'd0, rdy_bad}, 32'd0);
    if (v.lat == 0) begin
      chk("trap_no_start", 32'(st_n), 32'd0);
      chk("trap_done_latency", 32'(dn_k), 32'd0);
    end else begin
      chk("start_count", 32'(st_n), 32'd1);
      chk("start_latency", 32'(st_k), 32'(v.lat + busy_n));
      chk("done_latency", 32'(dn_k), 32'(v.lat + busy_n + 4));
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("in_ready_after_fin", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_start_done"}, {30'd0, div_start, done}, 32'd0);
    chk({tag, "_flags"}, {30'd0, err_div0, zero_q}, 32'd0);
    chk({tag, "_div_a"}, div_a, 32'd0);
    chk({tag, "_div_b"}, div_b, 32'd0);
    chk({tag, "_shifts"}, {22'd0, sx, sy}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{32'hC0000000, 32'h80000000, 32'hC0000000, 32'h80000000, 5'd0,  5'd0,  1'b0, 1'b0, 1};
    vecs[1] = '{32'h00000003, 32'h00000001, 32'hC0000000, 32'h80000000, 5'd30, 5'd31, 1'b0, 1'b0, 32};
    vecs[2] = '{32'h12345678, 32'h00000000, 32'h12345678, 32'h00000000, 5'd0,  5'd0,  1'b1, 1'b0, 0};
    vecs[3] = '{32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 5'd0,  5'd0,  1'b1, 1'b0, 0};
    vecs[4] = '{32'h00000000, 32'h00000005, 32'h00000000, 32'h00000005, 5'd0,  5'd0,  1'b0, 1'b1, 0};
    vecs[5] = '{32'h00010000, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 5'd15, 5'd0,  1'b0, 1'b0, 16};
    vecs[6] = '{32'h00000001, 32'h40000000, 32'h80000000, 32'h80000000, 5'd31, 5'd1,  1'b0, 1'b0, 32};
    vecs[7] = '{32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 5'd0,  5'd31, 1'b0, 1'b0, 32};

    clr = 1'b1; in_valid = 1'b0; x = '0; y = '0; div_busy = 1'b0; div_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    clr = 1'b0;

    foreach (vecs[i]) run(vecs[i], 0, 1'b0, 32'd0, 32'd0);

    // Busy divider for 5 ISSUE cycles, in_valid held into the next pair.
    run(vecs[0], 5, 1'b1, vecs[5].x, vecs[5].y);
    run(vecs[5], 0, 1'b0, 32'd0, 32'd0);

    // Reset during WAIT; a late div_ready must not produce done.
    x = 32'hC0000000; y = 32'h80000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 clr = 1'b1;
    #1 chk_reset_vals("mid_reset");
    #1 clr = 1'b0;
    @(posedge clk); #1 div_ready = 1'b1;
    @(posedge clk); #1 div_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("no_done_after_reset", {31'd0, done}, 32'd0);
      chk("idle_after_reset", {31'd0, in_ready}, 32'd1);
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
